hicore_branch_predictor: RTL and testbench

Parametrised branch prediction and resolution unit for the HiCore RV32 pipeline, and the successor to the purely combinational branch resolver. It predicts next-PC for fetch from a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. It takes resolved outcomes from the execute stage, raises a flush/redirect on misprediction, and trains its tables on the next clock edge.

---
 rtl/hicore_branch_predictor_pkg.sv | 32 +++
 rtl/hicore_sat_counter.sv | 37 +++
 rtl/hicore_branch_predictor.sv | 116 +++++++++++
 tb/tb_hicore_branch_predictor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hicore_branch_predictor_pkg.sv
// Shared defaults and training-action encoding for the HiCore branch predictor.
// The three defaults are the PC width, the BTB index width and the direction counter width.
package hicore_branch_predictor_pkg;

    localparam int HICORE_PC_SIZE = 32;
    localparam int HICORE_BTB_IDX = 4;
    localparam int HICORE_BHT_CNT = 2;

    typedef enum logic [2:0] {
        TRAIN_NONE,
        TRAIN_HIT_JUMP,
        TRAIN_HIT_TAKEN,
        TRAIN_HIT_NOT_TAKEN,
        TRAIN_ALLOC_JUMP,
        TRAIN_ALLOC_BRANCH
    } train_e;

    // A resolved not-taken branch that misses the table leaves the table unchanged.
    function automatic train_e train_action(input logic hit,
                                            input logic is_jump,
                                            input logic taken);
        if (hit) begin
            if (is_jump)    return TRAIN_HIT_JUMP;
            else if (taken) return TRAIN_HIT_TAKEN;
            else            return TRAIN_HIT_NOT_TAKEN;
        end
        if (is_jump)    return TRAIN_ALLOC_JUMP;
        else if (taken) return TRAIN_ALLOC_BRANCH;
        return TRAIN_NONE;
    endfunction

endpackage

// File: rtl/hicore_sat_counter.sv
// Saturating direction counter for one BTB entry.
// Reset loads the weak-not-taken value 01..1. Counting never wraps past 0 or all-ones.
module hicore_sat_counter
    import hicore_branch_predictor_pkg::*;
#(
    parameter int WIDTH = HICORE_BHT_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             set_max,
    input  logic             set_weak_taken,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX        = '1;
    localparam logic [WIDTH-1:0] CNT_WEAK_TAKEN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] CNT_WEAK_NT    = CNT_WEAK_TAKEN - WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CNT_WEAK_NT;
        end else if (set_max) begin
            count <= CNT_MAX;
        end else if (set_weak_taken) begin
            count <= CNT_WEAK_TAKEN;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + WIDTH'(1);
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/hicore_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters. It makes a combinational
// prediction and a combinational resolution, and it trains the table on the next clock edge.
module hicore_branch_predictor
    import hicore_branch_predictor_pkg::*;
#(
    parameter int PC_SIZE  = HICORE_PC_SIZE,
    parameter int IDX_BITS = HICORE_BTB_IDX,
    parameter int CNT_BITS = HICORE_BHT_CNT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_SIZE-1:0] if_pc,
    output logic               pred_taken,
    output logic [PC_SIZE-1:0] pred_pc,
    input  logic               upd_valid,
    input  logic [PC_SIZE-1:0] upd_pc,
    input  logic               upd_is_jump,
    input  logic               upd_taken,
    input  logic [PC_SIZE-1:0] upd_target,
    input  logic               upd_pred_taken,
    input  logic [PC_SIZE-1:0] upd_pred_pc,
    output logic               flush,
    output logic [PC_SIZE-1:0] redirect_pc
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_LSB  = IDX_BITS + 2;
    localparam int TAG_BITS = PC_SIZE - TAG_LSB;
    localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [PC_SIZE-1:0]  target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_BITS-1:0] if_tag, upd_tag;
    logic                if_hit, upd_hit;

    assign if_idx  = if_pc[IDX_BITS+1:2];
    assign if_tag  = if_pc[PC_SIZE-1:TAG_LSB];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
    assign upd_tag = upd_pc[PC_SIZE-1:TAG_LSB];

    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // The prediction reads the table as it was before this edge, so there is no bypass from training.
    always_comb begin
        pred_taken = if_hit && cnt_q[if_idx][CNT_BITS-1];
        pred_pc    = pred_taken ? target_q[if_idx] : (if_pc + PC_STEP);
    end

    logic               act_taken;
    logic [PC_SIZE-1:0] act_next;

    always_comb begin
        act_taken   = upd_is_jump || upd_taken;
        act_next    = act_taken ? upd_target : (upd_pc + PC_STEP);
        flush       = upd_valid && (act_next != upd_pred_pc);
        redirect_pc = flush ? act_next : '0;
    end

    // The carried predicted PC already encodes direction, so the flush decision never needs this bit.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    train_e action;
    logic   do_alloc;
    logic   do_write_target;

    always_comb begin
        action          = upd_valid ? train_action(upd_hit, upd_is_jump, upd_taken) : TRAIN_NONE;
        do_alloc        = (action == TRAIN_ALLOC_JUMP) || (action == TRAIN_ALLOC_BRANCH);
        do_write_target = do_alloc || (action == TRAIN_HIT_JUMP) || (action == TRAIN_HIT_TAKEN);
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic sel;
        assign sel = (upd_idx == IDX_BITS'(i));

        hicore_sat_counter #(
            .WIDTH(CNT_BITS)
        ) u_cnt (
            .clk           (clk),
            .rst           (rst),
            .inc           (sel && (action == TRAIN_HIT_TAKEN)),
            .dec           (sel && (action == TRAIN_HIT_NOT_TAKEN)),
            .set_max       (sel && ((action == TRAIN_HIT_JUMP) || (action == TRAIN_ALLOC_JUMP))),
            .set_weak_taken(sel && (action == TRAIN_ALLOC_BRANCH)),
            .count         (cnt_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (do_alloc) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // NOTE: tag and target arrays are deliberately left out of reset; a cleared
    // valid bit already hides them, and resetting a storage array wastes a reset net per bit.
    always_ff @(posedge clk) begin
        if (!rst && do_write_target) begin
            target_q[upd_idx] <= upd_target;
        end
        if (!rst && do_alloc) begin
            tag_q[upd_idx] <= upd_tag;
        end
    end

endmodule

// File: tb/tb_hicore_branch_predictor.sv
// Table-driven bench for hicore_branch_predictor. Expected outputs are queued when a
// vector is driven, then popped and compared on the following falling edge.
module tb_hicore_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_pc;
    logic        flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    hicore_branch_predictor #(
        .PC_SIZE (32),
        .IDX_BITS(4),
        .CNT_BITS(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_is_jump   (upd_is_jump),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_pc   (upd_pred_pc),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] if_pc;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_is_jump;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic [31:0] upd_pred_pc;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic        exp_flush;
        logic [31:0] exp_redirect;
    } vec_t;

    typedef struct {
        string       name;
        logic        taken;
        logic [31:0] pc;
        logic        flush;
        logic [31:0] redirect;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_vectors = 0;
    int   n_miss    = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t idle(input string name, input logic [31:0] pc,
                                  input logic exp_taken, input logic [31:0] exp_pc);
        vec_t v;
        v = '{name, 1'b0, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
              exp_taken, exp_pc, 1'b0, 32'h0};
        return v;
    endfunction

    function automatic vec_t upd(input string name, input logic [31:0] pc,
                                 input logic [31:0] u_pc, input logic jump, input logic taken,
                                 input logic [31:0] target, input logic [31:0] u_pred_pc,
                                 input logic exp_taken, input logic [31:0] exp_pc,
                                 input logic exp_flush, input logic [31:0] exp_redirect);
        vec_t v;
        v = '{name, 1'b0, pc, 1'b1, u_pc, jump, taken, target, u_pred_pc,
              exp_taken, exp_pc, exp_flush, exp_redirect};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = v.rst;
        if_pc          = v.if_pc;
        upd_valid      = v.upd_valid;
        upd_pc         = v.upd_pc;
        upd_is_jump    = v.upd_is_jump;
        upd_taken      = v.upd_taken;
        upd_target     = v.upd_target;
        upd_pred_pc    = v.upd_pred_pc;
        upd_pred_taken = (v.upd_pred_pc != v.upd_pc + 32'd4);
        sb.push_back('{v.name, v.exp_taken, v.exp_pc, v.exp_flush, v.exp_redirect});
        @(negedge clk);
        e = sb.pop_front();
        check({e.name, ".pred_taken"},  {31'b0, pred_taken}, {31'b0, e.taken});
        check({e.name, ".pred_pc"},     pred_pc,             e.pc);
        check({e.name, ".flush"},       {31'b0, flush},      {31'b0, e.flush});
        check({e.name, ".redirect_pc"}, redirect_pc,         e.redirect);
        n_vectors++;
    endtask

    initial begin
        vec_t v;

        // Main table: learning, saturation, target hold on not-taken, aliasing, no-alloc.
        v = idle("rst_hold", 32'h100, 1'b0, 32'h104); v.rst = 1'b1; tbl.push_back(v);
        tbl.push_back(idle("reset_state", 32'h100, 1'b0, 32'h104));
        tbl.push_back(upd("first_taken",  32'h100, 32'h100, 0, 1, 32'h80,  32'h104, 0, 32'h104, 1, 32'h80));
        tbl.push_back(idle("learned",     32'h100, 1'b1, 32'h80));
        tbl.push_back(upd("taken_1",      32'h100, 32'h100, 0, 1, 32'h80,  32'h80,  1, 32'h80,  0, 32'h0));
        tbl.push_back(upd("taken_2",      32'h100, 32'h100, 0, 1, 32'h80,  32'h80,  1, 32'h80,  0, 32'h0));
        tbl.push_back(upd("taken_3",      32'h100, 32'h100, 0, 1, 32'h80,  32'h80,  1, 32'h80,  0, 32'h0));
        tbl.push_back(upd("nt_1",         32'h100, 32'h100, 0, 0, 32'h500, 32'h80,  1, 32'h80,  1, 32'h104));
        tbl.push_back(idle("still_taken", 32'h100, 1'b1, 32'h80));
        tbl.push_back(upd("nt_2",         32'h100, 32'h100, 0, 0, 32'h80,  32'h80,  1, 32'h80,  1, 32'h104));
        tbl.push_back(idle("now_nt",      32'h100, 1'b0, 32'h104));
        tbl.push_back(upd("nt_3",         32'h100, 32'h100, 0, 0, 32'h80,  32'h104, 0, 32'h104, 0, 32'h0));
        tbl.push_back(upd("nt_sat",       32'h100, 32'h100, 0, 0, 32'h80,  32'h104, 0, 32'h104, 0, 32'h0));
        tbl.push_back(upd("up_from_0",    32'h100, 32'h100, 0, 1, 32'h80,  32'h104, 0, 32'h104, 1, 32'h80));
        tbl.push_back(idle("cnt_01",      32'h100, 1'b0, 32'h104));
        tbl.push_back(upd("up_from_1",    32'h100, 32'h100, 0, 1, 32'h80,  32'h104, 0, 32'h104, 1, 32'h80));
        tbl.push_back(idle("cnt_10",      32'h100, 1'b1, 32'h80));
        tbl.push_back(idle("alias_miss",  32'h140, 1'b0, 32'h144));
        tbl.push_back(upd("alias_evict",  32'h100, 32'h140, 0, 1, 32'h300, 32'h144, 1, 32'h80,  1, 32'h300));
        tbl.push_back(idle("evicted",     32'h100, 1'b0, 32'h104));
        tbl.push_back(idle("alias_hit",   32'h140, 1'b1, 32'h300));
        tbl.push_back(upd("miss_nt",      32'h208, 32'h208, 0, 0, 32'h600, 32'h20C, 0, 32'h20C, 0, 32'h0));
        tbl.push_back(idle("no_alloc",    32'h208, 1'b0, 32'h20C));
        tbl.push_back(idle("pc_wrap",     32'hFFFF_FFFC, 1'b0, 32'h0));

        rst = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_pc = '0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) apply(tbl[i]);

        // Reset coinciding with a taken allocate: reset wins, and learned state is wiped.
        v = upd("rst_and_upd", 32'h208, 32'h208, 0, 1, 32'h400, 32'h20C, 0, 32'h20C, 1, 32'h400);
        v.rst = 1'b1;
        apply(v);
        apply(idle("rst_no_train", 32'h208, 1'b0, 32'h20C));
        apply(idle("rst_wiped",    32'h140, 1'b0, 32'h144));

        // jal allocates at all-ones; a hit on a jump forces the counter back to all-ones.
        apply(upd("jal_alloc",   32'h40, 32'h40, 1, 0, 32'h200, 32'h44,  0, 32'h44,  1, 32'h200));
        apply(idle("jal_pred",   32'h40, 1'b1, 32'h200));
        apply(upd("jal_sat",     32'h40, 32'h40, 1, 0, 32'h200, 32'h200, 1, 32'h200, 0, 32'h0));
        apply(upd("jal_br_nt",   32'h40, 32'h40, 0, 0, 32'h200, 32'h200, 1, 32'h200, 1, 32'h44));
        apply(idle("jal_cnt_10", 32'h40, 1'b1, 32'h200));
        apply(upd("br_nt_2",     32'h40, 32'h40, 0, 0, 32'h200, 32'h200, 1, 32'h200, 1, 32'h44));
        apply(upd("jal_setmax",  32'h40, 32'h40, 1, 0, 32'h240, 32'h44,  0, 32'h44,  1, 32'h240));
        apply(upd("br_nt_3",     32'h40, 32'h40, 0, 0, 32'h240, 32'h240, 1, 32'h240, 1, 32'h44));
        apply(idle("max_then_10", 32'h40, 1'b1, 32'h240));

        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
        $finish;
    end

endmodule
